// File: rtl/int8_dot_pkg.sv
// int8_dot_pkg
// Shared definitions for the int8 dot-product scheduler: lane geometry,
// accumulator width, default MAC-tree latency and the scheduler FSM states.
package int8_dot_pkg;

    localparam int LANES        = 8;   // int8 lanes per chunk
    localparam int LANE_W       = 8;   // width of one operand lane
    localparam int ACC_W        = 32;  // accumulator / tree_out width
    localparam int TREE_LAT_DEF = 2;   // default MAC-tree latency in cycles

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : int8_dot_pkg

// File: rtl/int8_dot_tag_pipe.sv
// int8_dot_tag_pipe
// Delay line carrying a valid/last tag alongside each chunk sent into the
// external MAC tree, so the scheduler knows which tree_out samples to add.
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears all tags)
//   i_vld, i_last   tag entering on an accept edge
//   o_vld, o_last   tag at the final (DEPTH-th) stage
module int8_dot_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_vld,
    input  logic i_last,
    output logic o_vld,
    output logic o_last
);

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld  <= '0;
            r_last <= '0;
        end else begin
            r_vld[0]  <= i_vld;
            r_last[0] <= i_vld & i_last;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_last[i] <= r_last[i-1];
            end
        end
    end

    assign o_vld  = r_vld[DEPTH-1];
    assign o_last = r_last[DEPTH-1];

endmodule : int8_dot_tag_pipe

// File: rtl/int8_dot_sched.sv
// int8_dot_sched
// Streams 8-lane int8 operand chunks into an external MAC tree and
// accumulates the tree's per-chunk sums into a 32-bit signed dot product.
// Optional feature: define INT8_DOT_BIAS_EN to add a 'bias' input that seeds
// the accumulator on the first chunk of each vector (otherwise it starts at 0).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     operand chunk handshake; in_a/in_b 8 x int8 lanes
//   in_last               chunk ends the vector
//   tree_in               registered operands to the MAC tree (a_k, b_k pairs)
//   tree_out              signed 8-product sum returned TREE_LAT cycles later
//   res_valid/res_ready   result handshake; res_data, res_chunks, res_trunc
//   busy                  FSM is not IDLE
//   bias                  (INT8_DOT_BIAS_EN only) initial accumulator value
module int8_dot_sched
    import int8_dot_pkg::*;
#(
    parameter int MAX_CHUNKS = 256,
    parameter int TREE_LAT   = TREE_LAT_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
`ifdef INT8_DOT_BIAS_EN
    input  logic signed [ACC_W-1:0]       bias,
`endif
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*LANE_W-1:0]       in_a,
    input  logic [LANES*LANE_W-1:0]       in_b,
    input  logic                          in_last,
    output logic [2*LANES*LANE_W-1:0]     tree_in,
    input  logic signed [ACC_W-1:0]       tree_out,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic signed [ACC_W-1:0]       res_data,
    output logic [$clog2(MAX_CHUNKS):0]   res_chunks,
    output logic                          res_trunc,
    output logic                          busy
);

    localparam int                CNT_W   = $clog2(MAX_CHUNKS) + 1;
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_CHUNKS);

    state_t r_state, w_state_nxt;

    logic [2*LANES*LANE_W-1:0] r_tree_in, w_tree_pack;
    logic signed [ACC_W-1:0]   r_acc, r_res_data, w_acc_init;
    logic [CNT_W-1:0]          r_count, w_count_nxt, r_res_chunks;
    logic                      r_trunc, r_res_trunc;
    logic                      w_accept, w_last, w_trunc_hit;
    logic                      w_tag_vld, w_tag_last;

    // ---------------- accept qualification ----------------
    assign w_accept    = in_valid && in_ready;
    assign w_count_nxt = (r_state == ST_IDLE) ? CNT_W'(1) : r_count + CNT_W'(1);
    // Hitting the chunk limit forces the vector to end even without in_last.
    assign w_trunc_hit = (w_count_nxt == MAX_CNT) && !in_last;
    assign w_last      = in_last || (w_count_nxt == MAX_CNT);

`ifdef INT8_DOT_BIAS_EN
    assign w_acc_init = bias;
`else
    assign w_acc_init = '0;
`endif

    // Lane k of a sits in the low byte of tree pair k, lane k of b in the high byte.
    always_comb begin
        w_tree_pack = '0;
        for (int k = 0; k < LANES; k++) begin
            w_tree_pack[2*LANE_W*k +: LANE_W]          = in_a[LANE_W*k +: LANE_W];
            w_tree_pack[2*LANE_W*k + LANE_W +: LANE_W] = in_b[LANE_W*k +: LANE_W];
        end
    end

    int8_dot_tag_pipe #(
        .DEPTH (TREE_LAT)
    ) u_tag_pipe (
        .clk    (clk),
        .reset  (reset),
        .i_vld  (w_accept),
        .i_last (w_last),
        .o_vld  (w_tag_vld),
        .o_last (w_tag_last)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = w_last ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (w_accept && w_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_tag_vld && w_tag_last) w_state_nxt = ST_DONE;
            ST_DONE:  if (res_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (r_state == ST_IDLE) || (r_state == ST_RUN);
        busy      = (r_state != ST_IDLE);
        res_valid = (r_state == ST_DONE);
    end

    // ---------------- datapath: operands, count, accumulator, result ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tree_in    <= '0;
            r_count      <= '0;
            r_trunc      <= 1'b0;
            r_acc        <= '0;
            r_res_data   <= '0;
            r_res_chunks <= '0;
            r_res_trunc  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tree_in <= w_tree_pack;
                r_count   <= w_count_nxt;
                if (r_state == ST_IDLE) r_trunc <= w_trunc_hit;
                else if (w_trunc_hit)   r_trunc <= 1'b1;
            end
            // A new vector never overlaps a pending tag: the previous one fully
            // drained before IDLE, so the seed load and tree adds are exclusive.
            if (w_accept && r_state == ST_IDLE) r_acc <= w_acc_init;
            else if (w_tag_vld)                 r_acc <= r_acc + tree_out;
            if (w_tag_vld && w_tag_last) begin
                r_res_data   <= r_acc + tree_out;
                r_res_chunks <= r_count;
                r_res_trunc  <= r_trunc;
            end
        end
    end

    assign tree_in    = r_tree_in;
    assign res_data   = r_res_data;
    assign res_chunks = r_res_chunks;
    assign res_trunc  = r_res_trunc;

endmodule : int8_dot_sched

// File: tb/tb_int8_dot_sched.sv
// tb_int8_dot_sched
// Directed bench for int8_dot_sched with a behavioural MAC tree in the parent.
// Built with MAX_CHUNKS=4 so the chunk-limit path is reachable. Define
// INT8_DOT_BIAS_EN to build and check the bias variant.
module tb_int8_dot_sched;

    localparam int MAXC = 4;
    localparam int TL   = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_last;
    logic [63:0]  in_a, in_b;
    logic [127:0] tree_in;
    logic signed [31:0] tree_out;
    logic         res_valid, res_ready, res_trunc, busy;
    logic signed [31:0] res_data;
    logic [2:0]   res_chunks;
    logic signed [31:0] bias;

    int n_vec = 0;
    int n_err = 0;
    int exp_d;

    always #5 clk = ~clk;

    int8_dot_sched #(
        .MAX_CHUNKS (MAXC),
        .TREE_LAT   (TL)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
`ifdef INT8_DOT_BIAS_EN
        .bias       (bias),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .tree_in    (tree_in),
        .tree_out   (tree_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_chunks (res_chunks),
        .res_trunc  (res_trunc),
        .busy       (busy)
    );

    // Behavioural MAC tree: combinational 8-product sum, one register stage,
    // so tree_out is sampled TL=2 edges after the tree_in update edge.
    int w_sum;
    always_comb begin
        w_sum = 0;
        for (int k = 0; k < 8; k++)
            w_sum += int'($signed(tree_in[16*k +: 8])) * int'($signed(tree_in[16*k+8 +: 8]));
    end
    always_ff @(posedge clk) begin
        if (reset) tree_out <= '0;
        else       tree_out <= w_sum;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one chunk with every lane set to a / b; in_ready must be high at the edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_a     = {8{a}};
        in_b     = {8{b}};
        in_last  = last;
        chk("in_ready_at_accept", 32'(in_ready), 32'd1);
        tick();
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = '0;
        in_b     = '0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("consume_valid", 32'(res_valid), 32'd0);
        chk("consume_busy",  32'(busy),      32'd0);
    endtask

    initial begin
        reset = 1'b1; res_ready = 1'b0; bias = '0;
        idle_in();
        tick(); tick();
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_res_data",  res_data,       32'd0);
        chk("rst_tree_in",   32'(|tree_in),  32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_busy",     32'(busy),     32'd0);

        // Single chunk of ones: 8 x 1 = 8, result TL edges after the accept.
        send(8'd1, 8'd1, 1'b1);
        idle_in();
        chk("t1_busy",       32'(busy),      32'd1);
        chk("t1_valid_e0",   32'(res_valid), 32'd0);
        chk("t1_tree_lane0", 32'(tree_in[15:0]), 32'h0101);
        tick();
        chk("t1_valid_e1",   32'(res_valid), 32'd0);
        tick();
        chk("t1_valid_e2",   32'(res_valid), 32'd1);
        chk("t1_data",       res_data,       32'd8);
        chk("t1_chunks",     32'(res_chunks), 32'd1);
        chk("t1_trunc",      32'(res_trunc),  32'd0);
        consume();

        // Four back-to-back chunks of -128 x -128: 4 x 8 x 16384 = 524288.
        for (int i = 0; i < 4; i++) send(8'h80, 8'h80, i == 3);
        idle_in();
        tick();
        chk("t2_valid_early", 32'(res_valid), 32'd0);
        tick();
        chk("t2_valid",  32'(res_valid),  32'd1);
        chk("t2_data",   res_data,        32'd524288);
        chk("t2_chunks", 32'(res_chunks), 32'd4);
        chk("t2_trunc",  32'(res_trunc),  32'd0);
        // Result held while the consumer stalls.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_data",  res_data,        32'd524288);
            chk("t2_hold_ready", 32'(in_ready),   32'd0);
            chk("t2_hold_busy",  32'(busy),       32'd1);
        end
        consume();
        chk("t2_idle_ready", 32'(in_ready), 32'd1);

        // One chunk of 2 x -3 = -48 per vector, plus bias when built in.
        bias = 32'sd1000;
        send(8'd2, 8'hFD, 1'b1);
        idle_in();
        bias = 32'sd0;
        tick(); tick();
`ifdef INT8_DOT_BIAS_EN
        exp_d = 952;
`else
        exp_d = -48;
`endif
        chk("t3_valid", 32'(res_valid), 32'd1);
        chk("t3_data",  res_data,       exp_d);
        consume();

        // Five chunks offered without in_last: only four taken, vector truncated.
        for (int i = 0; i < 4; i++) send(8'd1, 8'd1, 1'b0);
        in_valid = 1'b1;          // fifth chunk stays offered
        chk("t4_5th_ready_d0", 32'(in_ready), 32'd0);
        tick();
        chk("t4_5th_ready_d1", 32'(in_ready), 32'd0);
        tick();
        chk("t4_valid",  32'(res_valid),  32'd1);
        chk("t4_data",   res_data,        32'd32);
        chk("t4_chunks", 32'(res_chunks), 32'd4);
        chk("t4_trunc",  32'(res_trunc),  32'd1);
        chk("t4_5th_ready_done", 32'(in_ready), 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t4_ready_after_consume", 32'(in_ready), 32'd1);
        // The fifth chunk now starts a fresh single-chunk vector.
        send(8'd1, 8'd1, 1'b1);
        idle_in();
        tick(); tick();
        chk("t4b_data",   res_data,        32'd8);
        chk("t4b_chunks", 32'(res_chunks), 32'd1);
        chk("t4b_trunc",  32'(res_trunc),  32'd0);
        consume();

        // Reset one cycle after the second accept of a running vector.
        send(8'd5, 8'd5, 1'b0);
        send(8'd5, 8'd5, 1'b0);
        idle_in();
        reset = 1'b1;
        tick();
        chk("t5_rst_busy",   32'(busy),       32'd0);
        chk("t5_rst_valid",  32'(res_valid),  32'd0);
        chk("t5_rst_ready",  32'(in_ready),   32'd1);
        chk("t5_rst_data",   res_data,        32'd0);
        chk("t5_rst_chunks", 32'(res_chunks), 32'd0);
        chk("t5_rst_trunc",  32'(res_trunc),  32'd0);
        chk("t5_rst_tree",   32'(|tree_in),   32'd0);
        reset = 1'b0;
        tick();
        // 3 x -1 per lane = -24, with nothing left over from the aborted chunks.
        send(8'd3, 8'hFF, 1'b1);
        idle_in();
        tick(); tick();
        chk("t5_valid",  32'(res_valid),  32'd1);
        chk("t5_data",   res_data,        -32'sd24);
        chk("t5_chunks", 32'(res_chunks), 32'd1);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_int8_dot_sched

// File: doc/int8_dot_sched.md
INT8_DOT_SCHED -- requirements
Module: int8_dot_sched

Interface
REQ-001 SHALL have parameter MAX_CHUNKS, default 256: maximum number of 8-lane chunks per dot product.
REQ-002 SHALL have parameter TREE_LAT, default 2: cycles from a tree_in update edge to the edge where tree_out is sampled.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand chunk offered.
REQ-006 SHALL have port in_ready, output, 1 bit: chunk accepted on a clock edge when in_valid is also high.
REQ-007 SHALL have port in_a, input, 64 bits: 8 signed int8 lanes, lane k at [8k+7:8k].
REQ-008 SHALL have port in_b, input, 64 bits: 8 signed int8 lanes, same lane layout as in_a.
REQ-009 SHALL have port in_last, input, 1 bit: the chunk is the final chunk of the vector.
REQ-010 SHALL have port tree_in, output, 128 bits: tree operands; [16k+7:16k] is a lane k (tree in(2k)) and [16k+15:16k+8] is b lane k (tree in(2k+1)).
REQ-011 SHALL have port tree_out, input, 32 bits: signed sum of the 8 products from the MAC tree.
REQ-012 SHALL have port res_valid, output, 1 bit: result held.
REQ-013 SHALL have port res_ready, input, 1 bit: result consumed on a clock edge when res_valid is also high.
REQ-014 SHALL have port res_data, output, 32 bits: signed accumulated dot product.
REQ-015 SHALL have port res_chunks, output, clog2(MAX_CHUNKS)+1 bits: number of chunks accumulated.
REQ-016 SHALL have port res_trunc, output, 1 bit: vector was cut off at MAX_CHUNKS.
REQ-017 SHALL have port busy, output, 1 bit: high when the FSM state is not IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-019 SHALL drive in_ready high only in IDLE or RUN.
REQ-020 SHALL, on accept in IDLE: clear the accumulator (or load the bias, see REQ-031), set count=1, register the operands into tree_in and go to RUN, or to DRAIN if the chunk is last.
REQ-021 SHALL, on each accept in RUN: register the operands into tree_in, increment count, and go to DRAIN if the chunk is last.
REQ-022 SHALL treat an accepted chunk as last when in_last=1 or count reaches MAX_CHUNKS; the MAX_CHUNKS case without in_last sets res_trunc=1.
REQ-023 SHALL carry a valid/last tag for each accept through a TREE_LAT-deep tag pipeline; a tag at its final stage causes acc += tree_out on that edge.
REQ-024 SHALL hold tree_in unchanged on cycles with no accept; the tags, not tree_in, qualify tree_out.
REQ-025 SHALL, when the final-stage tag carries last, load res_data with the final sum, enter DONE and raise res_valid; last accept at edge E0 gives res_valid high after edge E0+TREE_LAT.
REQ-026 SHALL keep res_data, res_chunks and res_trunc stable in DONE until the res_valid && res_ready edge, then go to IDLE with res_valid=0.
REQ-027 SHALL support full-rate accepts in RUN, one chunk per cycle, with no bubbles.
REQ-028 SHALL use wrap-around two's-complement 32-bit accumulation (worst case 256 x 131072 = 2^25 fits with no overflow).

Reset
REQ-029 SHALL, while reset=1 on an edge, enter IDLE and clear acc, count, all tags, tree_in, res_data, res_chunks, res_trunc and res_valid to 0, including reset mid-RUN, mid-DRAIN or mid-DONE.
REQ-030 SHALL hold in_ready=1 and busy=0 on the first cycle after reset is released.

Configuration
REQ-031 SHALL, with INT8_DOT_BIAS_EN defined, add the input port bias (32 bits, signed), sampled on the IDLE accept as the initial accumulator value.
REQ-032 SHALL, without INT8_DOT_BIAS_EN, have no bias port and start the accumulator at 0.

Structure
REQ-033 SHALL place LANES=8, the lane widths, the default TREE_LAT and the FSM state enum in the shared package int8_dot_pkg.
REQ-034 SHALL implement the tag pipeline as one sub-module, int8_dot_tag_pipe (parameter DEPTH, inputs vld/last, outputs vld/last at the final stage).
REQ-035 SHALL leave the MAC tree outside int8_dot_sched, connected at the parent level with the same clk and reset.

Verification
REQ-036 SHALL cover a single chunk with all lanes a=1, b=1 and in_last=1 -> res_data=8, res_chunks=1, res_valid high TREE_LAT cycles after the accept edge.
REQ-037 SHALL cover 4 back-to-back chunks with all lanes a=-128, b=-128 -> res_data=524288, res_chunks=4, in_ready high through all 4 accepts.
REQ-038 SHALL cover INT8_DOT_BIAS_EN with bias=1000 and one chunk of all lanes a=2, b=-3 -> res_data=952; without the macro, the same stimulus -> res_data=-48.
REQ-039 SHALL cover MAX_CHUNKS=4 with 5 chunks offered without in_last -> 4 accepted, res_trunc=1, in_ready=0 for the 5th until the result is consumed.
REQ-040 SHALL cover res_ready held low for 5 cycles in DONE -> res_data constant, in_ready=0, busy=1; res_ready=1 -> IDLE on the next edge.
REQ-041 SHALL cover reset asserted one cycle after the second accept in RUN -> all outputs 0, IDLE; a following 1-chunk vector gives the correct result with no contribution from the earlier chunks.
